nibble_compare_sequencer: RTL and testbench

//  Compares two multi-nibble unsigned operands by reusing the 4-bit gate-level comparator.

---
 rtl/nibble_compare_sequencer_if.sv | 37 +++
 rtl/nibble_compare_sequencer.sv | 136 +++++++++++++
 tb/tb_nibble_compare_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_compare_sequencer_if.sv
// ------------------------------------------------------------------
// nibble_compare_sequencer_if : host handshake + comparator bus
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface nibble_compare_sequencer_if #(
  parameter int NIBBLES = 4
);
  logic                 start;
  logic [4*NIBBLES-1:0] a_in;
  logic [4*NIBBLES-1:0] b_in;
  logic [3:0]           cmp_a;
  logic [3:0]           cmp_b;
  logic                 cmp_agb;
  logic                 cmp_aeb;
  logic                 cmp_alb;
  logic                 busy;
  logic                 done;
  logic                 gt;
  logic                 eq;
  logic                 lt;
  logic                 err;

  modport slave (
    input  start, a_in, b_in, cmp_agb, cmp_aeb, cmp_alb,
    output cmp_a, cmp_b, busy, done, gt, eq, lt, err
  );

  modport master (
    output start, a_in, b_in, cmp_agb, cmp_aeb, cmp_alb,
    input  cmp_a, cmp_b, busy, done, gt, eq, lt, err
  );
endinterface

`default_nettype wire

// File: rtl/nibble_compare_sequencer.sv
// ------------------------------------------------------------------
// nibble_compare_sequencer : MSB-first nibble-serial compare via an
// external 4-bit comparator. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module nibble_compare_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  nibble_compare_sequencer_if.slave      ctrl_io
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] C_IDX_MSB = IDXW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic [W-1:0]    a_q,     a_d;
  logic [W-1:0]    b_q,     b_d;
  logic            gt_q,    gt_d;
  logic            eq_q,    eq_d;
  logic            lt_q,    lt_d;
  logic            err_q,   err_d;

  logic [3:0]      nib_a_w;
  logic [3:0]      nib_b_w;
  logic [2:0]      flags_w;

  // Nibble select as an explicit mux so every operand bit is used.
  always_comb begin
    nib_a_w = 4'h0;
    nib_b_w = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib_a_w = a_q[4*i +: 4];
        nib_b_w = b_q[4*i +: 4];
      end
    end
  end

  assign flags_w = {ctrl_io.cmp_agb, ctrl_io.cmp_aeb, ctrl_io.cmp_alb};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_io.start) begin
          a_d     = ctrl_io.a_in;
          b_d     = ctrl_io.b_in;
          idx_d   = C_IDX_MSB;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        case (flags_w)
          3'b100: begin
            gt_d    = 1'b1;
            state_d = ST_DONE;
          end
          3'b001: begin
            lt_d    = 1'b1;
            state_d = ST_DONE;
          end
          3'b010: begin
            if (idx_q == '0) begin
              eq_d    = 1'b1;
              state_d = ST_DONE;
            end else begin
              idx_d = idx_q - IDXW'(1);
            end
          end
          // Non-one-hot flags mean a broken comparator; flag it and stop.
          default: begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      err_q   <= err_d;
    end
  end

  assign ctrl_io.cmp_a = (state_q == ST_RUN) ? nib_a_w : 4'h0;
  assign ctrl_io.cmp_b = (state_q == ST_RUN) ? nib_b_w : 4'h0;
  assign ctrl_io.busy  = (state_q != ST_IDLE);
  assign ctrl_io.done  = (state_q == ST_DONE);
  assign ctrl_io.gt    = gt_q;
  assign ctrl_io.eq    = eq_q;
  assign ctrl_io.lt    = lt_q;
  assign ctrl_io.err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_compare_sequencer.sv
// ------------------------------------------------------------------
// tb_nibble_compare_sequencer : scoreboard bench, NIBBLES=4 and 1. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_nibble_compare_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault4 = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [3:0] q4[$];
  logic [3:0] q1[$];
  logic [3:0] e4, e1;

  always #5 clk = ~clk;

  nibble_compare_sequencer_if #(.NIBBLES(4)) bus4();
  nibble_compare_sequencer_if #(.NIBBLES(1)) bus1();

  nibble_compare_sequencer #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .ctrl_io(bus4));
  nibble_compare_sequencer #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .ctrl_io(bus1));

  // Behavioural 4-bit comparator; fault4 forces an illegal AgB+AlB pattern.
  always_comb begin
    bus4.cmp_agb = fault4 ? 1'b1 : (bus4.cmp_a > bus4.cmp_b);
    bus4.cmp_aeb = fault4 ? 1'b0 : (bus4.cmp_a == bus4.cmp_b);
    bus4.cmp_alb = fault4 ? 1'b1 : (bus4.cmp_a < bus4.cmp_b);
    bus1.cmp_agb = (bus1.cmp_a > bus1.cmp_b);
    bus1.cmp_aeb = (bus1.cmp_a == bus1.cmp_b);
    bus1.cmp_alb = (bus1.cmp_a < bus1.cmp_b);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {gt,eq,lt,err}
  function automatic logic [3:0] ref_res(input logic [15:0] a, input logic [15:0] b);
    return {a > b, a == b, a < b, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus4.done === 1'b1) begin
      if (q4.size() == 0) begin
        check("dut4_unexpected_done", 32'd1, 32'd0);
      end else begin
        e4 = q4.pop_front();
        check("dut4_result", {bus4.gt, bus4.eq, bus4.lt, bus4.err}, e4);
      end
    end
    if (!rst && bus1.done === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_result", {bus1.gt, bus1.eq, bus1.lt, bus1.err}, e1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle4();
    int n = 0;
    while (bus4.busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("dut4_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (bus1.busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("dut1_idle_timeout", 32'd1, 32'd0);
  endtask

  // Returns in cycle 1 of the compare (one edge after start was sampled).
  task automatic start4(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] exp, input bit push);
    wait_idle4();
    bus4.a_in  = a;
    bus4.b_in  = b;
    bus4.start = 1'b1;
    if (push) q4.push_back(exp);
    tick();
    bus4.start = 1'b0;
    bus4.a_in  = ~a;
    bus4.b_in  = ~b;
  endtask

  task automatic start1(input logic [3:0] a, input logic [3:0] b);
    wait_idle1();
    bus1.a_in  = a;
    bus1.b_in  = b;
    bus1.start = 1'b1;
    q1.push_back(ref_res({12'h0, a}, {12'h0, b}));
    tick();
    bus1.start = 1'b0;
  endtask

  initial begin
    logic [3:0] na[4];
    logic [3:0] nb[4];
    logic [15:0] ra, rb;
    na = '{4'h1, 4'h2, 4'h3, 4'h4};
    nb = '{4'h1, 4'h2, 4'h3, 4'h5};
    bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
    bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0;

    // reset
    rst = 1'b1;
    repeat (2) tick();
    check("rst_dut4_outputs", {bus4.cmp_a, bus4.cmp_b, bus4.busy, bus4.done,
                               bus4.gt, bus4.eq, bus4.lt, bus4.err}, 32'h0);
    check("rst_dut1_outputs", {bus1.cmp_a, bus1.cmp_b, bus1.busy, bus1.done,
                               bus1.gt, bus1.eq, bus1.lt, bus1.err}, 32'h0);
    rst = 1'b0;
    tick();

    // MSB mismatch
    start4(16'hF000, 16'h0FFF, 4'b1000, 1);
    check("msb_cmp_a_c1", bus4.cmp_a, 32'hF);
    check("msb_cmp_b_c1", bus4.cmp_b, 32'h0);
    check("msb_busy_c1", bus4.busy, 32'd1);
    tick();
    check("msb_done_c2", {bus4.done, bus4.gt}, 32'b11);
    tick();
    check("msb_busy_c3", bus4.busy, 32'd0);

    // LSB mismatch
    start4(16'h1234, 16'h1235, 4'b0010, 1);
    for (int i = 0; i < 4; i++) begin
      check("lsb_cmp_a", bus4.cmp_a, {28'h0, na[i]});
      check("lsb_cmp_b", bus4.cmp_b, {28'h0, nb[i]});
      check("lsb_not_done", bus4.done, 32'd0);
      tick();
    end
    check("lsb_done_c5", {bus4.done, bus4.lt}, 32'b11);

    // equal and hold
    start4(16'hABCD, 16'hABCD, 4'b0100, 1);
    repeat (4) tick();
    check("eq_done_c5", {bus4.done, bus4.eq}, 32'b11);
    repeat (10) tick();
    check("eq_hold", {bus4.busy, bus4.done, bus4.gt, bus4.eq, bus4.lt, bus4.err}, 32'b000100);
    start4(16'h0001, 16'h0000, 4'b1000, 1);
    check("eq_cleared_by_start", {bus4.gt, bus4.eq, bus4.lt, bus4.err}, 32'h0);

    // start held through RUN and DONE must not queue a second compare
    start4(16'h5555, 16'h5555, 4'b0100, 1);
    bus4.start = 1'b1;
    bus4.a_in  = 16'hFFFF;
    bus4.b_in  = 16'h0000;
    repeat (4) tick();
    check("proto_done_c5", {bus4.done, bus4.eq}, 32'b11);
    tick();
    bus4.start = 1'b0;
    check("proto_idle_after_done", bus4.busy, 32'd0);
    repeat (3) tick();
    check("proto_no_restart", bus4.busy, 32'd0);

    // reset in cycle 2 of a compare; rst+start together
    start4(16'h1111, 16'h1111, 4'b0000, 0);
    tick();
    rst = 1'b1;
    bus4.start = 1'b1;
    tick();
    check("midrst_outputs", {bus4.cmp_a, bus4.cmp_b, bus4.busy, bus4.done,
                             bus4.gt, bus4.eq, bus4.lt, bus4.err}, 32'h0);
    tick();
    rst = 1'b0;
    bus4.start = 1'b0;
    check("midrst_start_dropped", bus4.busy, 32'd0);
    repeat (6) tick();
    check("midrst_still_idle", bus4.busy, 32'd0);

    // comparator fault
    fault4 = 1'b1;
    start4(16'h1234, 16'h1234, 4'b0001, 1);
    tick();
    check("fault_done", bus4.done, 32'd1);
    wait_idle4();
    fault4 = 1'b0;

    // NIBBLES=4 sweep: equal, single-bit-different and random pairs
    for (int i = 0; i < 240; i++) begin
      ra = 16'($urandom);
      case (i % 3)
        0:       rb = ra;
        1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      start4(ra, rb, ref_res(ra, rb), 1);
    end
    wait_idle4();

    // NIBBLES=1 exhaustive
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start1(4'(a), 4'(b));
        check("n1_single_run_cycle", bus1.cmp_a, 32'(a));
      end
    end
    wait_idle1();

    repeat (4) tick();
    check("dut4_queue_drained", q4.size(), 32'd0);
    check("dut1_queue_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
